// File: rtl/tuner_pkg.sv
// tuner_pkg: constants and types shared by the tuner datapath blocks
// (mixer, CIC decimator and downstream filters).
package tuner_pkg;

   localparam int TUNER_DSZ         = 16;
   localparam int CIC_N_DEF         = 4;
   localparam int CIC_RMAX_LOG2_DEF = 6;

   // CIC register growth: every integrator/comb stage can add log2(RMAX) bits.
   function automatic int cic_aw(input int dsz, input int n, input int rmax_log2);
      return dsz + n * rmax_log2;
   endfunction

   typedef logic signed [TUNER_DSZ-1:0] sample_t;

endpackage

// File: rtl/saturator.sv
// saturator: clamps a signed ISZ-bit value into the signed OSZ-bit range.
module saturator #(
   parameter int ISZ = 41,
   parameter int OSZ = 16
) (
   input  logic signed [ISZ-1:0] din,
   output logic signed [OSZ-1:0] dout
);

   // In range when every bit above the output sign bit matches it.
   always_comb begin
      if ((&din[ISZ-1:OSZ-1]) || (~|din[ISZ-1:OSZ-1]))
         dout = din[OSZ-1:0];
      else if (din[ISZ-1])
         dout = {1'b1, {(OSZ-1){1'b0}}};
      else
         dout = {1'b0, {(OSZ-1){1'b1}}};
   end

endmodule

// File: rtl/tuner_cic_decimator.sv
// tuner_cic_decimator: programmable-rate N-stage CIC decimator behind the
// tuner mixer. Output rounding is round-half-up followed by a right shift.
// Optional feature macro TUNER_CIC_SAT_EN: saturate instead of wrapping the
// final DSZ-bit reduction.
module tuner_cic_decimator
   import tuner_pkg::*;
#(
   parameter int DSZ       = TUNER_DSZ,
   parameter int N         = CIC_N_DEF,
   parameter int RMAX_LOG2 = CIC_RMAX_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [RMAX_LOG2:0]    rate,
   input  logic [5:0]            shift,
   input  logic                  in_valid,
   input  logic signed [DSZ-1:0] in,
   output logic signed [DSZ-1:0] out,
   output logic                  out_valid
);

   localparam int AW = cic_aw(DSZ, N, RMAX_LOG2);
   localparam int VW = AW + 1;
   localparam int RW = RMAX_LOG2 + 1;
   localparam logic [RW-1:0] RMAX = RW'(2 ** RMAX_LOG2);
   localparam logic [5:0]    SMAX = 6'(AW - DSZ);

   logic [RW-1:0]         rate_c;
   logic [RW-1:0]         r_rate;
   logic [RW-1:0]         cnt;
   logic [5:0]            shift_c;
   logic [5:0]            r_shift;
   logic                  dec_ev;
   logic signed [AW-1:0]  cap;
   logic                  cap_tok;
   logic [5:0]            cap_sh;
   logic signed [AW-1:0]  integ_last;
   logic signed [AW-1:0]  comb_last;
   logic                  tok_last;
   logic [5:0]            sh_last;
   logic signed [VW-1:0]  v_sum;
   logic signed [DSZ-1:0] v_red;

   // Clamp requested rate/shift into the legal range before latching.
   always_comb begin
      rate_c = rate;
      if (rate < RW'(2))
         rate_c = RW'(2);
      else if (rate > RMAX)
         rate_c = RMAX;
      shift_c = (shift > SMAX) ? SMAX : shift;
   end

   assign dec_ev = in_valid && (cnt == r_rate - RW'(1));

   for (genvar k = 0; k < N; k++) begin : g_integ
      logic signed [AW-1:0] acc;
      logic signed [AW-1:0] addend;
      if (k == 0) begin : g_first
         assign addend = {{(AW-DSZ){in[DSZ-1]}}, in};
      end else begin : g_next
         assign addend = g_integ[k-1].acc;
      end
      // Pipelined integrator: adds the previous stage's registered sum, wraps freely.
      always_ff @(posedge clk) begin
         if (reset)
            acc <= '0;
         else if (in_valid)
            acc <= acc + addend;
      end
   end
   assign integ_last = g_integ[N-1].acc;

   // Frame counter, comb-input capture, and rate/shift latching at frame ends.
   // The shift that governs a frame travels with its token so a later
   // shift change cannot retroactively affect an in-flight sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         cap     <= '0;
         cap_tok <= 1'b0;
         cap_sh  <= '0;
         r_rate  <= rate_c;
         r_shift <= shift_c;
      end else begin
         cap_tok <= dec_ev;
         if (in_valid)
            cnt <= dec_ev ? '0 : cnt + RW'(1);
         if (dec_ev) begin
            cap     <= integ_last;
            cap_sh  <= r_shift;
            r_rate  <= rate_c;
            r_shift <= shift_c;
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_comb
      logic signed [AW-1:0] c;
      logic signed [AW-1:0] x_prev;
      logic signed [AW-1:0] x_in;
      logic                 tok;
      logic                 t_in;
      logic [5:0]           sh;
      logic [5:0]           s_in;
      if (k == 0) begin : g_first
         assign x_in = cap;
         assign t_in = cap_tok;
         assign s_in = cap_sh;
      end else begin : g_next
         assign x_in = g_comb[k-1].c;
         assign t_in = g_comb[k-1].tok;
         assign s_in = g_comb[k-1].sh;
      end
      // Comb stage: difference against the last value this stage accepted.
      always_ff @(posedge clk) begin
         if (reset) begin
            c      <= '0;
            x_prev <= '0;
            tok    <= 1'b0;
            sh     <= '0;
         end else begin
            tok <= t_in;
            if (t_in) begin
               c      <= x_in - x_prev;
               x_prev <= x_in;
               sh     <= s_in;
            end
         end
      end
   end
   assign comb_last = g_comb[N-1].c;
   assign tok_last  = g_comb[N-1].tok;
   assign sh_last   = g_comb[N-1].sh;

   // Add half an output LSB one bit wider than the accumulator so it cannot overflow.
   always_comb begin
      v_sum = {comb_last[AW-1], comb_last};
      if (sh_last != 6'd0)
         v_sum = v_sum + (VW'(1) << (sh_last - 6'd1));
   end

`ifdef TUNER_CIC_SAT_EN
   logic signed [VW-1:0] v;
   assign v = v_sum >>> sh_last;
   saturator #(.ISZ(VW), .OSZ(DSZ)) u_sat (.din(v), .dout(v_red));
`else
   assign v_red = DSZ'(v_sum >>> sh_last);
`endif

   // Output register: value held between strobes, one-cycle valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= tok_last;
         if (tok_last)
            out <= v_red;
      end
   end

endmodule

// File: tb/tb_tuner_cic_decimator.sv
// tb_tuner_cic_decimator: randomized and directed bench against a sample-level
// CIC model (integrate, decimate, N-th difference, round, reduce).
module tb_tuner_cic_decimator;

   localparam int DSZ = 16;
   localparam int N   = 4;
   localparam int AW  = 40;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [6:0]            rate;
   logic [5:0]            shift;
   logic                  in_valid;
   logic signed [DSZ-1:0] din;
   logic signed [DSZ-1:0] out;
   logic                  out_valid;

   int checks = 0;
   int errors = 0;

   tuner_cic_decimator dut (
      .clk(clk), .reset(reset), .rate(rate), .shift(shift),
      .in_valid(in_valid), .in(din), .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct { longint cyc; longint val; } exp_t;

   longint                xs[$];
   longint                cs[$];
   exp_t                  expq[$];
   int                    frame_cnt;
   int                    cur_rate;
   int                    cur_shift;
   longint                cyc = 0;
   logic                  exp_valid;
   logic signed [DSZ-1:0] exp_out;

   function automatic int clamp_rate(input int r);
      return (r < 2) ? 2 : ((r > 64) ? 64 : r);
   endfunction

   function automatic int clamp_shift(input int s);
      return (s > AW - DSZ) ? AW - DSZ : s;
   endfunction

   function automatic longint choose(input int a, input int b);
      longint r = 1;
      if (b < 0 || a < b) return 0;
      for (int i = 1; i <= b; i++) r = r * (a - b + i) / i;
      return r;
   endfunction

   // N-fold running sum of the input samples, evaluated at sample index n.
   function automatic longint cumsum(input int n);
      longint s = 0;
      for (int i = 0; i <= n; i++) s += xs[i] * choose(n - i + N - 1, N - 1);
      return s;
   endfunction

   // N-th difference of the decimated sequence, then round, shift and reduce.
   function automatic longint model_out(input int sh);
      longint y = 0;
      longint c40;
      longint v;
      logic signed [DSZ-1:0] t;
      int j = cs.size() - 1;
      for (int k = 0; k <= N; k++)
         if (j - k >= 0) y += ((k % 2) ? -1 : 1) * choose(N, k) * cs[j - k];
      c40 = y & ((64'sd1 <<< AW) - 1);
      if (c40[AW-1]) c40 -= (64'sd1 <<< AW);
      v = (c40 + ((sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0)) >>> sh;
`ifdef TUNER_CIC_SAT_EN
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`else
      t = v[DSZ-1:0];
      v = t;
`endif
      return v;
   endfunction

   task automatic cycle(input logic v, input logic signed [DSZ-1:0] x);
      exp_t e;
      in_valid = v;
      din      = x;
      @(posedge clk);
      cyc++;
      if (reset) begin
         xs.delete(); cs.delete(); expq.delete();
         frame_cnt = 0;
         cur_rate  = clamp_rate(int'(rate));
         cur_shift = clamp_shift(int'(shift));
         exp_out   = '0;
      end else if (v) begin
         xs.push_back(longint'(x));
         frame_cnt++;
         if (frame_cnt == cur_rate) begin
            frame_cnt = 0;
            cs.push_back(cumsum(xs.size() - 1 - N));
            e.cyc = cyc + N + 1;
            e.val = model_out(cur_shift);
            expq.push_back(e);
            cur_rate  = clamp_rate(int'(rate));
            cur_shift = clamp_shift(int'(shift));
         end
      end
      #1;
      exp_valid = 1'b0;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
         exp_valid = 1'b1;
         e = expq.pop_front();
         exp_out = DSZ'(e.val);
      end
   endtask

   task automatic apply_reset(input int r, input int s);
      rate  = 7'(r);
      shift = 6'(s);
      reset = 1'b1;
      cycle(1'b0, '0);
      cycle(1'b0, '0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(16, 16);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out !== 16'sd0) begin errors++; $display("FAIL reset_out: got %0d want 0", out); end
   endtask

   task automatic test_dc_unity();
      int nstr = 0;
      longint last = 0;
      apply_reset(16, 16);
      for (int i = 0; i < 16 * 12; i++) begin
         cycle(1'b1, 16'sd1000);
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL dc_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL dc_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
         if (out_valid) begin
            if (nstr >= N + 1) begin
               checks++; if (out !== 16'sd1000) begin errors++; $display("FAIL dc_steady: got %0d want 1000", out); end
               checks++; if (cyc - last != 16) begin errors++; $display("FAIL dc_spacing: got %0d want 16", cyc - last); end
            end
            last = cyc;
            nstr++;
         end
      end
      checks++; if (nstr < 10) begin errors++; $display("FAIL dc_strobes: got %0d want >= 10", nstr); end
   endtask

   task automatic test_impulse();
      longint ev = 0;
      longint first = -1;
      longint sum = 0;
      int nz = 0;
      apply_reset(4, 0);
      for (int i = 0; i < 60; i++) begin
         cycle(1'b1, (i == 0) ? 16'sd1 : 16'sd0);
         if (i == 3) ev = cyc;
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL imp_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL imp_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
         if (out_valid) begin
            if (first < 0) first = cyc;
            sum += out;
            if (out != 0) nz++;
         end
      end
      checks++; if (first - ev != N + 1) begin errors++; $display("FAIL imp_latency: got %0d edges want %0d", first - ev, N + 1); end
      checks++; if (sum != 64 || nz != 3) begin errors++; $display("FAIL imp_response: got sum %0d nonzero %0d want 64 and 3", sum, nz); end
   endtask

   task automatic test_saturation();
      int nstr = 0;
      logic signed [DSZ-1:0] want;
`ifdef TUNER_CIC_SAT_EN
      want = 16'sd32767;
`else
      want = -16'sd2;
`endif
      apply_reset(16, 15);
      for (int i = 0; i < 16 * 10; i++) begin
         cycle(1'b1, 16'sd32767);
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL sat_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL sat_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
         if (out_valid) begin
            if (nstr >= N + 1) begin
               checks++; if (out !== want) begin errors++; $display("FAIL sat_steady: got %0d want %0d", out, want); end
            end
            nstr++;
         end
      end
   endtask

   task automatic test_rounding();
      for (int pass = 0; pass < 2; pass++) begin
         int nstr = 0;
         logic signed [DSZ-1:0] x;
         logic signed [DSZ-1:0] want;
         x    = (pass == 0) ? 16'sd1 : -16'sd1;
         want = (pass == 0) ? 16'sd1 : 16'sd0;
         apply_reset(2, 5);
         for (int i = 0; i < 40; i++) begin
            cycle(1'b1, x);
            checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
            checks++; if (out !== exp_out) begin errors++; $display("FAIL rnd_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
            if (out_valid) begin
               if (nstr >= N + 1) begin
                  checks++; if (out !== want) begin errors++; $display("FAIL rnd_steady: got %0d want %0d (in %0d)", out, want, x); end
               end
               nstr++;
            end
         end
      end
   endtask

   task automatic test_gapped();
      int nstr = 0;
      longint last = 0;
      apply_reset(8, 12);
      for (int i = 0; i < 24 * 12; i++) begin
         cycle((i % 3) == 0, -16'sd500);
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL gap_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL gap_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
         if (out_valid) begin
            if (nstr >= N + 1) begin
               checks++; if (out !== -16'sd500) begin errors++; $display("FAIL gap_steady: got %0d want -500", out); end
               checks++; if (cyc - last != 24) begin errors++; $display("FAIL gap_spacing: got %0d want 24", cyc - last); end
            end
            last = cyc;
            nstr++;
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int first = -1;
      apply_reset(8, 12);
      for (int i = 0; i < 35; i++) begin
         cycle(1'b1, 16'($urandom));
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rmf_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL rmf_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 16'($urandom));
         checks++; if (out_valid !== 1'b0 || out !== 16'sd0) begin errors++; $display("FAIL rmf_in_reset: got out %0d valid %b want 0 0", out, out_valid); end
      end
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 16'($urandom));
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rmf_post_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL rmf_post_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
         if (first < 0) begin
            if (out_valid) first = i;
            else begin
               checks++; if (out !== 16'sd0) begin errors++; $display("FAIL rmf_hold_zero: got %0d want 0", out); end
            end
         end
      end
      checks++; if (first != 12) begin errors++; $display("FAIL rmf_first_strobe: got %0d want 12", first); end
   endtask

   task automatic test_rate_change();
      int nstr = 0;
      longint last = 0;
      longint sp[$];
      bit changed = 1'b0;
      apply_reset(8, 12);
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 16'($urandom));
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rc_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL rc_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
         if (out_valid) begin
            if (changed) sp.push_back(cyc - last);
            last = cyc;
            nstr++;
            if (nstr == 3 && !changed) begin
               rate    = 7'd32;
               changed = 1'b1;
            end
         end
      end
      checks++;
      if (sp.size() < 3) begin
         errors++; $display("FAIL rc_strobes: got %0d spacings want >= 3", sp.size());
      end else if (sp[0] != 8 || sp[1] != 32 || sp[2] != 32) begin
         errors++; $display("FAIL rc_spacing: got %0d,%0d,%0d want 8,32,32", sp[0], sp[1], sp[2]);
      end
   endtask

   task automatic test_random();
      for (int ep = 0; ep < 4; ep++) begin
         apply_reset(int'($urandom_range(0, 70)), int'($urandom_range(0, 30)));
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) rate = 7'($urandom_range(0, 70));
            if ($urandom_range(0, 39) == 0) shift = 6'($urandom_range(0, 30));
            cycle($urandom_range(0, 3) != 0, 16'($urandom));
            checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid: got %b want %b (cycle %0d)", out_valid, exp_valid, cyc); end
            checks++; if (out !== exp_out) begin errors++; $display("FAIL rand_out: got %0d want %0d (cycle %0d)", out, exp_out, cyc); end
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      rate     = 7'd16;
      shift    = 6'd16;
      in_valid = 1'b0;
      din      = '0;
      test_reset();
      test_dc_unity();
      test_impulse();
      test_saturation();
      test_rounding();
      test_gapped();
      test_reset_mid_frame();
      test_rate_change();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
